// File: rtl/vga_pattern_gen.sv
// Test-pattern stage behind the 640x480 VGA timing generator.
// It selects the pattern with a debounced button, updates the mode at frame start, and runs a two-stage pixel pipeline.
module vga_pattern_gen #(
  parameter int NUM_MODES       = 6,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit SYNC_INVERT     = 1'b1,
  parameter int H_DISPLAY       = 640,
  parameter int V_DISPLAY       = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pixel_en,
  input  logic [9:0] h_count,
  input  logic [9:0] v_count,
  input  logic       display_en,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       btn_mode,
  output logic [3:0] vga_r,
  output logic [3:0] vga_g,
  output logic [3:0] vga_b,
  output logic       h_sync_out,
  output logic       v_sync_out,
  output logic [2:0] mode,
  output logic [7:0] frame_cnt
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // ---------------- button path ----------------
  logic          btn_s1, btn_s2, btn_db, btn_db_q;
  logic [CW-1:0] db_cnt;
  logic          press;

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s1   <= 1'b0;
      btn_s2   <= 1'b0;
      btn_db   <= 1'b0;
      btn_db_q <= 1'b0;
      db_cnt   <= '0;
    end else begin
      btn_s1   <= btn_mode;
      btn_s2   <= btn_s1;
      btn_db_q <= btn_db;
      if (btn_s2 == btn_db) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        btn_db <= ~btn_db;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  assign press = btn_db & ~btn_db_q;

  // ---------------- mode / frame counter ----------------
  logic [2:0] mode_pending, pending_nxt;
  logic       frame_start;

  always_comb begin
    pending_nxt = mode_pending;
    if (press)
      pending_nxt = (mode_pending == 3'(NUM_MODES - 1)) ? 3'd0 : mode_pending + 3'd1;
  end

  assign frame_start = pixel_en && (h_count == 10'd0) && (v_count == 10'd0);

  // A press landing in the frame-start cycle is folded in via pending_nxt
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_pending <= 3'd0;
      mode         <= 3'd0;
      frame_cnt    <= 8'd0;
    end else begin
      mode_pending <= pending_nxt;
      if (frame_start) begin
        mode      <= pending_nxt;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  // ---------------- stage 1: register and pre-decode ----------------
  logic [2:0]  bar_idx, bar1;
  logic        grid, box;
  logic [10:0] box_left;
  logic [3:0]  ramp1;
  logic        de1, hs1, vs1, chk1, grid1, box1;

  always_comb begin
    bar_idx = 3'd7;
    for (int i = 6; i >= 0; i--)
      if (h_count < 10'((i + 1) * 80)) bar_idx = 3'(i);
  end

  assign grid = (h_count[4:0] == 5'd0) || (v_count[4:0] == 5'd0) ||
                (h_count == 10'(H_DISPLAY - 1)) || (v_count == 10'(V_DISPLAY - 1));

  assign box_left = {2'b00, frame_cnt, 1'b0};
  assign box = ({1'b0, h_count} >= box_left) && ({1'b0, h_count} < box_left + 11'd64) &&
               (v_count >= 10'd200) && (v_count < 10'd264);

  always_ff @(posedge clk) begin
    if (rst) begin
      de1   <= 1'b0;
      hs1   <= 1'b0;
      vs1   <= 1'b0;
      bar1  <= 3'd0;
      chk1  <= 1'b0;
      grid1 <= 1'b0;
      box1  <= 1'b0;
      ramp1 <= 4'd0;
    end else if (pixel_en) begin
      de1   <= display_en;
      hs1   <= h_sync_in;
      vs1   <= v_sync_in;
      bar1  <= bar_idx;
      chk1  <= h_count[5] ^ v_count[5];
      grid1 <= grid;
      box1  <= box;
      ramp1 <= h_count[9:6];
    end
  end

  // ---------------- stage 2: colour and syncs ----------------
  function automatic logic [11:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_rgb = 12'hFFF;
      3'd1:    bar_rgb = 12'hFF0;
      3'd2:    bar_rgb = 12'h0FF;
      3'd3:    bar_rgb = 12'h0F0;
      3'd4:    bar_rgb = 12'hF0F;
      3'd5:    bar_rgb = 12'hF00;
      3'd6:    bar_rgb = 12'h00F;
      default: bar_rgb = 12'h000;
    endcase
  endfunction

  logic [11:0] colour;

  always_comb begin
    colour = 12'h000;
    case (mode)
      3'd0: colour = bar_rgb(bar1);
      3'd1: colour = chk1 ? 12'h000 : 12'hFFF;
      3'd2: colour = {ramp1, ramp1, ramp1};
      3'd3: colour = grid1 ? 12'hFFF : 12'h000;
      3'd4: colour = bar_rgb(frame_cnt[7:5]);
      3'd5: colour = box1 ? 12'hF00 : 12'h00F;
      default: colour = 12'h000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      {vga_r, vga_g, vga_b} <= 12'h000;
      h_sync_out <= SYNC_INVERT;
      v_sync_out <= SYNC_INVERT;
    end else if (pixel_en) begin
      {vga_r, vga_g, vga_b} <= de1 ? colour : 12'h000;
      h_sync_out <= hs1 ^ SYNC_INVERT;
      v_sync_out <= vs1 ^ SYNC_INVERT;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: table of pixel vectors plus hand sequences for
// debounce, frame-start mode update, wraps, box pattern and mid-frame reset.
module tb_vga_pattern_gen;
  logic       clk = 1'b0, rst = 1'b1, pixel_en = 1'b0;
  logic [9:0] h_count = '0, v_count = '0;
  logic       display_en = 1'b0, h_sync_in = 1'b0, v_sync_in = 1'b0, btn_mode = 1'b0;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       h_sync_out, v_sync_out;
  logic [2:0] mode;
  logic [7:0] frame_cnt;
  logic [11:0] rgb;

  assign rgb = {vga_r, vga_g, vga_b};
  always #5 clk = ~clk;

  vga_pattern_gen #(.NUM_MODES(6), .DEBOUNCE_CYCLES(16), .SYNC_INVERT(1'b1),
                    .H_DISPLAY(640), .V_DISPLAY(480)) dut (
    .clk(clk), .rst(rst), .pixel_en(pixel_en), .h_count(h_count), .v_count(v_count),
    .display_en(display_en), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .btn_mode(btn_mode), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .h_sync_out(h_sync_out), .v_sync_out(v_sync_out), .mode(mode), .frame_cnt(frame_cnt));

  typedef struct packed {
    logic [2:0]  md;
    logic [9:0]  h, v;
    logic        de, hs, vs;
    logic [11:0] rgb;
    logic        hso, vso;
  } vec_t;

  vec_t tbl [19];
  int errors = 0, checks = 0;
  int exp_mode = 0, exp_pend = 0, exp_fc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // one strobe followed by one idle cycle; returns at the negedge after the strobe
  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic de,
                     input logic hs, input logic vs);
    @(negedge clk);
    h_count = h; v_count = v; display_en = de; h_sync_in = hs; v_sync_in = vs;
    pixel_en = 1'b1;
    @(negedge clk);
    pixel_en = 1'b0;
  endtask

  task automatic filler();
    pix(10'd700, 10'd10, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame_start();
    pix(10'd0, 10'd0, 1'b1, 1'b0, 1'b0);
    exp_mode = exp_pend;
    exp_fc = (exp_fc + 1) % 256;
  endtask

  task automatic press();
    @(negedge clk); btn_mode = 1'b1;
    repeat (40) @(negedge clk);
    btn_mode = 1'b0;
    repeat (40) @(negedge clk);
    exp_pend = (exp_pend + 1) % 6;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; btn_mode = 1'b0;
    @(negedge clk); rst = 1'b0;
    exp_mode = 0; exp_pend = 0; exp_fc = 0;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      while (exp_mode != int'(tbl[i].md)) begin
        press();
        frame_start();
      end
      pix(tbl[i].h, tbl[i].v, tbl[i].de, tbl[i].hs, tbl[i].vs);
      filler();
      chk($sformatf("row%0d_rgb", i), int'(rgb), int'(tbl[i].rgb));
      chk($sformatf("row%0d_hs", i), int'(h_sync_out), int'(tbl[i].hso));
      chk($sformatf("row%0d_vs", i), int'(v_sync_out), int'(tbl[i].vso));
    end
  endtask

  initial begin
    int lowcnt, first_low, nz;
    int seq [6];
    seq = '{1, 2, 3, 4, 5, 0};
    //            md    h        v        de   hs   vs   rgb       hso  vso
    tbl[0]  = '{3'd0, 10'd0,   10'd10,  1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};
    tbl[1]  = '{3'd0, 10'd79,  10'd10,  1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};
    tbl[2]  = '{3'd0, 10'd80,  10'd10,  1'b1,1'b0,1'b0, 12'hFF0, 1'b1,1'b1};
    tbl[3]  = '{3'd0, 10'd639, 10'd10,  1'b1,1'b0,1'b0, 12'h000, 1'b1,1'b1};
    tbl[4]  = '{3'd0, 10'd700, 10'd10,  1'b0,1'b0,1'b0, 12'h000, 1'b1,1'b1};
    tbl[5]  = '{3'd0, 10'd200, 10'd10,  1'b1,1'b0,1'b0, 12'h0FF, 1'b1,1'b1};
    tbl[6]  = '{3'd0, 10'd300, 10'd490, 1'b0,1'b0,1'b1, 12'h000, 1'b1,1'b0};
    tbl[7]  = '{3'd1, 10'd32,  10'd1,   1'b1,1'b0,1'b0, 12'h000, 1'b1,1'b1};
    tbl[8]  = '{3'd1, 10'd32,  10'd32,  1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};
    tbl[9]  = '{3'd1, 10'd1,   10'd1,   1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};
    tbl[10] = '{3'd2, 10'd639, 10'd10,  1'b1,1'b0,1'b0, 12'h999, 1'b1,1'b1};
    tbl[11] = '{3'd2, 10'd64,  10'd10,  1'b1,1'b0,1'b0, 12'h111, 1'b1,1'b1};
    tbl[12] = '{3'd2, 10'd128, 10'd10,  1'b0,1'b0,1'b0, 12'h000, 1'b1,1'b1};
    tbl[13] = '{3'd3, 10'd32,  10'd5,   1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};
    tbl[14] = '{3'd3, 10'd33,  10'd5,   1'b1,1'b0,1'b0, 12'h000, 1'b1,1'b1};
    tbl[15] = '{3'd3, 10'd639, 10'd5,   1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};
    tbl[16] = '{3'd3, 10'd100, 10'd479, 1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};
    tbl[17] = '{3'd3, 10'd100, 10'd478, 1'b1,1'b0,1'b0, 12'h000, 1'b1,1'b1};
    tbl[18] = '{3'd3, 10'd64,  10'd64,  1'b1,1'b0,1'b0, 12'hFFF, 1'b1,1'b1};

    // reset held 3 clocks with strobes toggling
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); pixel_en = ~pixel_en; h_count = 10'd5; v_count = 10'd10; display_en = 1'b1;
    end
    @(negedge clk);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_hs", int'(h_sync_out), 1);
    chk("rst_vs", int'(v_sync_out), 1);
    chk("rst_mode", int'(mode), 0);
    chk("rst_fc", int'(frame_cnt), 0);
    pixel_en = 1'b0; rst = 1'b0;
    pix(10'd100, 10'd10, 1'b0, 1'b0, 1'b0);
    pix(10'd5, 10'd10, 1'b1, 1'b0, 1'b0);
    chk("first_lat1", int'(rgb), 0);
    filler();
    chk("first_lat2", int'(rgb), 12'hFFF);
    @(negedge clk);
    chk("hold", int'(rgb), 12'hFFF);

    run_rows(0, 6);

    // hsync pulse 656..751 in mode 0
    lowcnt = 0; first_low = -1; nz = 0;
    for (int h = 650; h <= 760; h++) begin
      pix(10'(h), 10'd10, 1'b0, (h >= 656 && h <= 751), 1'b0);
      if (h_sync_out == 1'b0) begin
        lowcnt++;
        if (first_low < 0) first_low = h;
      end
      if (rgb != 12'h000) nz = 1;
    end
    chk("hs_low_len", lowcnt, 96);
    chk("hs_first_low", first_low, 657);
    chk("hs_rgb_blank", nz, 0);

    // debounce: glitch ignored, held press counted once, applied at frame start
    @(negedge clk); btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    btn_mode = 1'b0;
    repeat (40) @(negedge clk);
    frame_start();
    chk("glitch_mode", int'(mode), 0);
    press();
    chk("press_wait_mode", int'(mode), 0);
    frame_start();
    chk("press_mode", int'(mode), 1);
    chk("press_fc", int'(frame_cnt), exp_fc);

    run_rows(7, 18);

    // press pulse lands in the frame-start cycle
    @(negedge clk); btn_mode = 1'b1;
    repeat (18) @(posedge clk);
    @(negedge clk);
    chk("same_pre_mode", int'(mode), 3);
    h_count = 10'd0; v_count = 10'd0; display_en = 1'b1; pixel_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pixel_en = 1'b0;
    exp_pend = 4; exp_mode = 4; exp_fc = exp_fc + 1;
    chk("same_cycle_mode", int'(mode), 4);
    btn_mode = 1'b0;
    repeat (40) @(negedge clk);

    // solid colour follows frame_cnt[7:5]
    pix(10'd300, 10'd100, 1'b1, 1'b0, 1'b0); filler();
    chk("solid_fc_low", int'(rgb), 12'hFFF);
    while (exp_fc != 32) frame_start();
    pix(10'd300, 10'd100, 1'b1, 1'b0, 1'b0); filler();
    chk("solid_fc32", int'(rgb), 12'hFF0);
    while (exp_fc != 64) frame_start();
    pix(10'd300, 10'd100, 1'b1, 1'b0, 1'b0); filler();
    chk("solid_fc64", int'(rgb), 12'h0FF);

    // mode wrap across six frames
    do_reset();
    for (int r = 0; r < 6; r++) begin
      press();
      frame_start();
      chk($sformatf("wrap_mode%0d", r), int'(mode), seq[r]);
    end

    // moving box at frame_cnt=3 (left edge 6)
    do_reset();
    repeat (5) press();
    repeat (3) frame_start();
    chk("box_mode", int'(mode), 5);
    chk("box_fc", int'(frame_cnt), 3);
    pix(10'd6, 10'd210, 1'b1, 1'b0, 1'b0);   filler(); chk("box_h6", int'(rgb), 12'hF00);
    pix(10'd5, 10'd210, 1'b1, 1'b0, 1'b0);   filler(); chk("box_h5", int'(rgb), 12'h00F);
    pix(10'd70, 10'd210, 1'b1, 1'b0, 1'b0);  filler(); chk("box_h70", int'(rgb), 12'h00F);
    pix(10'd69, 10'd263, 1'b1, 1'b0, 1'b0);  filler(); chk("box_v263", int'(rgb), 12'hF00);
    pix(10'd6, 10'd264, 1'b1, 1'b0, 1'b0);   filler(); chk("box_v264", int'(rgb), 12'h00F);
    pix(10'd6, 10'd199, 1'b1, 1'b0, 1'b0);   filler(); chk("box_v199", int'(rgb), 12'h00F);

    // frame counter wrap
    repeat (252) frame_start();
    chk("fc_255", int'(frame_cnt), 255);
    frame_start();
    chk("fc_wrap", int'(frame_cnt), 0);

    // mid-frame reset in grid mode
    do_reset();
    repeat (3) press();
    frame_start();
    chk("mid_mode3", int'(mode), 3);
    pix(10'd320, 10'd240, 1'b1, 1'b0, 1'b0);
    pix(10'd321, 10'd240, 1'b1, 1'b0, 1'b0);
    chk("mid_pre_rgb", int'(rgb), 12'hFFF);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    exp_mode = 0; exp_pend = 0; exp_fc = 0;
    chk("mid_rst_rgb", int'(rgb), 0);
    chk("mid_rst_mode", int'(mode), 0);
    chk("mid_rst_fc", int'(frame_cnt), 0);
    chk("mid_rst_hs", int'(h_sync_out), 1);
    pix(10'd320, 10'd240, 1'b1, 1'b0, 1'b0);
    chk("mid_resume1", int'(rgb), 0);
    filler();
    chk("mid_resume2", int'(rgb), 12'hF0F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
